// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate, adds it to the PC,
// and presents the result through a two-entry valid/ready FIFO (head + skid).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       Imm_sel,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  target,
    output logic [TAG_W-1:0] out_tag,
    output logic             sel_err
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    // Handshake: a transfer happens on any rising edge where valid && ready are
    // both high; in_ready depends only on the registered count, never on out_ready.
    logic signed [31:0] raw;
    logic               raw_err;
    entry_t             new_entry;
    entry_t             head;
    entry_t             skid;
    logic [1:0]         count;
    logic               push;
    logic               pop;

    // Z and SH values keep bit 31 clear, so one sign-extending cast covers every format.
    always_comb begin
        raw     = '0;
        raw_err = 1'b0;
        case (Imm_sel)
            3'd0: raw = {{20{inst[31]}}, inst[31:20]};
            3'd1: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'd2: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd3: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd4: raw = {inst[31:12], 12'h000};
            3'd5: raw = {27'd0, inst[19:15]};
            3'd6: raw = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
            default: begin
                raw     = '0;
                raw_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        new_entry.imm    = XLEN'(raw);
        new_entry.target = in_pc + XLEN'(raw);
        new_entry.tag    = in_tag;
        new_entry.err    = raw_err;
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flush wins over any concurrent push or pop; held data is simply abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= new_entry;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head <= new_entry;
                        2'b10: begin
                            skid  <= new_entry;
                            count <= 2'd2;
                        end
                        2'b01: count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head  <= skid;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign imm     = head.imm;
    assign target  = head.target;
    assign out_tag = head.tag;
    assign sel_err = head.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN=32): directed decode vectors, backpressure, flush,
// async reset, and a randomized run against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       Imm_sel;
    logic [XLEN-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] out_tag;
    logic             sel_err;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .Imm_sel(Imm_sel), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .target(target), .out_tag(out_tag), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: field extraction by shifts, masks and weighted sums.
    function automatic exp_t ref_model(input logic [31:0] i, input logic [2:0] s,
                                       input logic [31:0] pc, input logic [4:0] t);
        exp_t        e;
        logic [31:0] v;
        v = 32'd0;
        case (s)
            3'd0: v = 32'($signed(i) >>> 20);
            3'd1: v = 32'(($signed(i) >>> 25) * 32) + ((i >> 7) & 32'd31);
            3'd2: v = (i[31] ? -32'd4096 : 32'd0) + ((i >> 7) & 32'd1) * 2048
                      + ((i >> 25) & 32'd63) * 32 + ((i >> 8) & 32'd15) * 2;
            3'd3: v = (i[31] ? -32'd1048576 : 32'd0) + ((i >> 12) & 32'd255) * 4096
                      + ((i >> 20) & 32'd1) * 2048 + ((i >> 21) & 32'd1023) * 2;
            3'd4: v = i & 32'hFFFF_F000;
            3'd5: v = (i >> 15) & 32'd31;
            3'd6: v = (i >> 20) & 32'd31;
            default: v = 32'd0;
        endcase
        e.imm    = v;
        e.target = pc + v;
        e.tag    = t;
        e.err    = (s == 3'd7);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; inst = '0; Imm_sel = '0; in_pc = '0; in_tag = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 0;
        rst = 1;
        #12;
        rst = 0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        vectors++;
        if (imm !== '0 || target !== '0 || out_tag !== '0 || sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: imm=%h target=%h tag=%h err=%b, want zeros",
                     imm, target, out_tag, sel_err);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ti[6];
        logic [2:0]  ts[6];
        logic [31:0] tp[6];
        logic [31:0] ei[6];
        logic [31:0] et[6];
        ti = '{32'hFFF00093, 32'h123450B7, 32'h000F8073, 32'hFE000EE3, 32'h0080006F, 32'h12345678};
        ts = '{3'd0, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
        tp = '{32'h0, 32'h0, 32'h0, 32'h100, 32'hFFFF_FFFC, 32'h40};
        ei = '{32'hFFFFFFFF, 32'h12345000, 32'h0000001F, 32'hFFFFFFFC, 32'h8, 32'h0};
        et = '{32'hFFFFFFFF, 32'h12345000, 32'h0000001F, 32'h000000FC, 32'h4, 32'h40};
        for (int k = 0; k < 6; k++) begin
            out_ready = 0;
            in_valid = 1; inst = ti[k]; Imm_sel = ts[k]; in_pc = tp[k]; in_tag = 5'(k + 8);
            step();
            in_valid = 0;
            vectors++;
            if (out_valid !== 1'b1 || imm !== ei[k] || target !== et[k] ||
                out_tag !== 5'(k + 8) || sel_err !== (ts[k] == 3'd7)) begin
                miscompares++;
                $display("FAIL decode_%0d: v=%b imm=%h tgt=%h tag=%0d err=%b, want 1 %h %h %0d %b",
                         k, out_valid, imm, target, out_tag, sel_err, ei[k], et[k], k + 8,
                         ts[k] == 3'd7);
            end
            out_ready = 1;
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL decode_pop_%0d: out_valid=%b, want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        Imm_sel = 3'd0; inst = 32'h0010_0093; in_pc = 32'h0;
        in_valid = 1; in_tag = 5'd1; step();
        in_tag = 5'd2; step();
        in_tag = 5'd3;
        vectors++;
        if (in_ready !== 1'b0 || out_tag !== 5'd1) begin
            miscompares++;
            $display("FAIL bp_full: in_ready=%b tag=%0d, want 0 1", in_ready, out_tag);
        end
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: in_ready=%b v=%b tag=%0d, want 0 1 1", in_ready, out_valid, out_tag);
        end
        out_ready = 1;
        step();
        vectors++;
        if (out_tag !== 5'd2 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain2: tag=%0d in_ready=%b, want 2 1", out_tag, in_ready);
        end
        step();
        in_valid = 0;
        vectors++;
        if (out_tag !== 5'd3 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain3: v=%b tag=%0d, want 1 3", out_valid, out_tag);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        in_valid = 1; Imm_sel = 3'd1; inst = 32'hABCD_1234;
        in_tag = 5'd4; step();
        in_tag = 5'd5; step();
        flush = 1; in_tag = 5'd6; step();
        flush = 0; in_valid = 0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_ghost: cycle %0d out_valid=%b tag=%0d, want 0", c, out_valid, out_tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        in_valid = 1; Imm_sel = 3'd4; inst = 32'hDEAD_B000; in_pc = 32'h1000;
        in_tag = 5'd9; step();
        in_tag = 5'd10; step();
        #2 rst = 1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || imm !== '0 || target !== '0 || out_tag !== '0 || sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: v=%b imm=%h tgt=%h tag=%0d err=%b, want zeros",
                     out_valid, imm, target, out_tag, sel_err);
        end
        in_valid = 0;
        step();
        rst = 0;
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_after: cycle %0d v=%b in_ready=%b, want 0 1", c, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        bit pop;
        exp_t e;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            inst      = $urandom;
            Imm_sel   = 3'($urandom_range(0, 7));
            in_pc     = $urandom;
            in_tag    = 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
                miscompares++;
                $display("FAIL rand_hs: n=%0d v=%b rdy=%b, want %b %b", n, out_valid, in_ready,
                         exp_q.size() > 0, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                vectors++;
                if (imm !== exp_q[0].imm || target !== exp_q[0].target ||
                    out_tag !== exp_q[0].tag || sel_err !== exp_q[0].err) begin
                    miscompares++;
                    $display("FAIL rand_data: n=%0d got %h/%h/%0d/%b want %h/%h/%0d/%b", n,
                             imm, target, out_tag, sel_err,
                             exp_q[0].imm, exp_q[0].target, exp_q[0].tag, exp_q[0].err);
                end
            end
            acc = in_valid && (exp_q.size() < 2) && !flush;
            pop = out_ready && (exp_q.size() > 0) && !flush;
            e = ref_model(inst, Imm_sel, in_pc, in_tag);
            step();
            if (flush) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(e);
            end
        end
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
